// File: rtl/avsd_dfll_gen_if.sv
// Control/status bundle for the digital frequency-locked clock generator.
//   ref_clk  : reference input, asynchronous to clk
//   enb_cp   : 1 freezes the half-period register
//   enb_vco  : 1 holds the generated clock low
//   filt_en  : 1 selects filtered half-period update
//   clk_out  : generated clock
//   tick     : one-cycle pulse on each clk_out rise
//   period   : current half-period, fixed point (FRAC_W fractional bits)
//   lock     : frequency lock status
//   ref_lost : reference missing status
interface avsd_dfll_gen_if #(
  parameter int unsigned PW = 24
);
  logic          ref_clk;
  logic          enb_cp;
  logic          enb_vco;
  logic          filt_en;
  logic          clk_out;
  logic          tick;
  logic [PW-1:0] period;
  logic          lock;
  logic          ref_lost;

  modport master (
    output ref_clk, enb_cp, enb_vco, filt_en,
    input  clk_out, tick, period, lock, ref_lost
  );

  modport slave (
    input  ref_clk, enb_cp, enb_vco, filt_en,
    output clk_out, tick, period, lock, ref_lost
  );
endinterface

// File: rtl/avsd_dfll_gen.sv
// Digital frequency-locked clock generator. Measures the reference period in
// clk cycles, derives the output half-period HP = period/2^(MULT_LOG2+1) in
// fixed point and generates clk_out with a fractional accumulator.
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : avsd_dfll_gen_if.slave (reference/controls in, clock/status out)
module avsd_dfll_gen #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned FRAC_W    = 8,
  parameter int unsigned MULT_LOG2 = 3,
  parameter int unsigned FILT_SH   = 2,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned TOL       = 16,
  parameter int unsigned INIT_HP   = 4 << FRAC_W
) (
  input logic            clk,
  input logic            rst_n,
  avsd_dfll_gen_if.slave bus
);
  localparam int unsigned PW      = CNT_W + FRAC_W;
  localparam int unsigned AW      = PW + 1;
  localparam int unsigned MEAS_SH = FRAC_W - MULT_LOG2 - 1;
  localparam int unsigned LCW     = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_MAX - CNT_W'(1);
  localparam logic [PW-1:0]    HP_ONE  = PW'(1) << FRAC_W;

  logic             ref_s1, ref_s2, ref_prev;
  logic [CNT_W-1:0] ref_cnt;
  logic             armed;
  logic             meas_vld;
  logic [PW-1:0]    hp_meas;
  logic [PW-1:0]    hp;
  logic [LCW-1:0]   lock_cnt;
  logic             lock_q, ref_lost_q;
  logic [AW-1:0]    acc;
  logic             clk_out_q, tick_q;

  logic                rise_c, sat_c, meas_ok_c, loss_c, in_tol_c, hit_c;
  logic [PW-1:0]       meas_c, abs_c, hp_sel_c, hp_new_c;
  logic signed [PW:0]  diff_c, step_c, sum_c;
  logic [AW-1:0]       acc_next_c;

  // Reference edge detection and measurement qualification
  assign rise_c    = ref_s2 & ~ref_prev;
  assign sat_c     = (ref_cnt == CNT_MAX);
  assign meas_ok_c = rise_c & armed & (ref_cnt < CNT_LIM);
  // An armed rise that comes too late is a loss, as is a saturated counter
  assign loss_c    = (rise_c & armed & ~meas_ok_c) | (~rise_c & sat_c);
  assign meas_c    = PW'(ref_cnt + CNT_W'(1)) << MEAS_SH;

  // Error against the pre-update half-period, shared by lock and filter
  assign diff_c   = $signed({1'b0, hp_meas}) - $signed({1'b0, hp});
  assign abs_c    = diff_c[PW] ? PW'(-diff_c) : PW'(diff_c);
  assign in_tol_c = (abs_c <= PW'(TOL));
  assign step_c   = diff_c >>> FILT_SH;
  // Filtered value lies between hp and hp_meas, so it is never negative
  assign sum_c    = $signed({1'b0, hp}) + step_c;
  assign hp_sel_c = bus.filt_en ? PW'(sum_c) : hp_meas;
  assign hp_new_c = (hp_sel_c < HP_ONE) ? HP_ONE : hp_sel_c;

  // Fractional accumulator compare
  assign acc_next_c = acc + AW'(HP_ONE);
  assign hit_c      = (acc_next_c >= {1'b0, hp});

  // Synchronizer, period counter, arming and measurement capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_s1   <= 1'b0;
      ref_s2   <= 1'b0;
      ref_prev <= 1'b0;
      ref_cnt  <= '0;
      armed    <= 1'b0;
      meas_vld <= 1'b0;
      hp_meas  <= '0;
    end else begin
      ref_s1   <= bus.ref_clk;
      ref_s2   <= ref_s1;
      ref_prev <= ref_s2;
      meas_vld <= meas_ok_c;
      if (meas_ok_c) hp_meas <= meas_c;
      if (rise_c) begin
        ref_cnt <= '0;
        armed   <= 1'b1;
      end else if (sat_c) begin
        armed <= 1'b0;
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
    end
  end

  // Lock / loss status and half-period update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp         <= PW'(INIT_HP);
      lock_cnt   <= '0;
      lock_q     <= 1'b0;
      ref_lost_q <= 1'b0;
    end else if (loss_c) begin
      lock_cnt   <= '0;
      lock_q     <= 1'b0;
      ref_lost_q <= 1'b1;
    end else if (meas_vld) begin
      ref_lost_q <= 1'b0;
      if (in_tol_c) begin
        if (lock_cnt != LCW'(LOCK_CNT)) lock_cnt <= lock_cnt + LCW'(1);
        if (lock_cnt >= LCW'(LOCK_CNT - 1)) lock_q <= 1'b1;
      end else begin
        lock_cnt <= '0;
        lock_q   <= 1'b0;
      end
      if (!bus.enb_cp) hp <= hp_new_c;
    end
  end

  // Output generator; remainder is carried so the long-run rate has no drift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else if (bus.enb_vco) begin
      acc       <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= hit_c & ~clk_out_q;
      if (hit_c) begin
        clk_out_q <= ~clk_out_q;
        acc       <= acc_next_c - {1'b0, hp};
      end else begin
        acc <= acc_next_c;
      end
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;
  assign bus.period   = hp;
  assign bus.lock     = lock_q;
  assign bus.ref_lost = ref_lost_q;
endmodule

// File: tb/tb_avsd_dfll_gen.sv
// Self-checking bench for avsd_dfll_gen (CNT_W=10, FRAC_W=8, MULT_LOG2=3,
// LOCK_CNT=4, TOL=16). A reference model predicts period/lock/ref_lost for
// every driven REF rise; predictions are queued and compared one REF period later.
module tb_avsd_dfll_gen;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned PW    = CNT_W + 8;
  localparam int          LOST_M = 1023;

  typedef struct {
    logic [PW-1:0] period;
    logic          lock;
    logic          ref_lost;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avsd_dfll_gen_if #(.PW(PW)) bus ();

  avsd_dfll_gen #(
    .CNT_W(CNT_W), .FRAC_W(8), .MULT_LOG2(3), .FILT_SH(2),
    .LOCK_CNT(4), .TOL(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tick_cnt = 0;
  exp_t sb_q[$];

  // reference model state
  int m_hp, m_lc, last_rise;
  bit m_armed, m_lock, m_lost;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tick === 1'b1) tick_cnt <= tick_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hp = 32'h400; m_lc = 0; m_armed = 0; m_lock = 0; m_lost = 0;
    last_rise = cyc;
    sb_q.delete();
  endtask

  // Predict the effect of one REF rise and queue it
  task automatic model_rise();
    int m, meas, d, ad;
    exp_t e;
    m = cyc - last_rise;
    last_rise = cyc;
    if (!m_armed) begin
      m_armed = 1;
    end else if (m >= LOST_M) begin
      m_lost = 1; m_lock = 0; m_lc = 0;
    end else begin
      meas = m * 16;
      d = meas - m_hp;
      ad = (d < 0) ? -d : d;
      m_lost = 0;
      if (ad <= 16) begin
        if (m_lc < 4) m_lc++;
        if (m_lc >= 4) m_lock = 1;
      end else begin
        m_lc = 0; m_lock = 0;
      end
      if (!bus.enb_cp) begin
        m_hp = bus.filt_en ? (m_hp + (d >>> 2)) : meas;
        if (m_hp < 256) m_hp = 256;
      end
    end
    e.period = PW'(m_hp);
    e.lock = m_lock;
    e.ref_lost = m_lost;
    sb_q.push_back(e);
  endtask

  // n REF periods of p cycles; each prediction is checked just before the next rise
  task automatic ref_cycles(input string tag, input int p, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ref_clk = 1'b1;
      model_rise();
      repeat (p / 2) @(negedge clk);
      bus.ref_clk = 1'b0;
      repeat (p - p / 2 - 1) @(negedge clk);
      if (sb_q.size() == 0) begin
        check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq($sformatf("%s[%0d].period", tag, i), 32'(bus.period), 32'(e.period));
        check_eq($sformatf("%s[%0d].lock", tag, i), 32'(bus.lock), 32'(e.lock));
        check_eq($sformatf("%s[%0d].lost", tag, i), 32'(bus.ref_lost), 32'(e.ref_lost));
      end
    end
  endtask

  task automatic count_ticks(input int w, output int n);
    int t0;
    @(negedge clk);
    t0 = tick_cnt;
    repeat (w) @(negedge clk);
    n = tick_cnt - t0;
  endtask

  // Wait (sampling at negedges) until clk_out equals lvl; n = cycles waited
  task automatic wait_level(input string tag, input logic lvl, input int budget, output int n);
    n = 0;
    while (bus.clk_out !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq({tag, ".timeout"}, 32'(bus.clk_out), 32'(lvl));
  endtask

  task automatic high_len(input string tag, output int h);
    int dummy;
    wait_level(tag, 1'b0, 100, dummy);
    wait_level(tag, 1'b1, 100, dummy);
    wait_level(tag, 1'b0, 100, h);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".period"}, 32'(bus.period), 32'h400);
    check_eq({tag, ".lock"}, 32'(bus.lock), 32'd0);
    check_eq({tag, ".lost"}, 32'(bus.ref_lost), 32'd0);
    check_eq({tag, ".clk_out"}, 32'(bus.clk_out), 32'd0);
    check_eq({tag, ".tick"}, 32'(bus.tick), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, h, t0;
    bus.ref_clk = 1'b0;
    bus.enb_cp  = 1'b0;
    bus.enb_vco = 1'b0;
    bus.filt_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    model_reset();

    // direct update at 160-cycle reference
    ref_cycles("p160", 160, 6);
    check_eq("p160.hp", 32'(bus.period), 32'h0A00);
    check_eq("p160.lock", 32'(bus.lock), 32'd1);
    count_ticks(160, n);
    check_eq("p160.ticks", 32'(n), 32'd8);
    high_len("p160.high", h);
    check_eq("p160.high", 32'(h), 32'd10);

    // fractional half-period 6.25
    ref_cycles("p100", 100, 3);
    check_eq("p100.hp", 32'(bus.period), 32'h0640);
    count_ticks(100, n);
    check_eq("p100.ticks100", 32'(n), 32'd8);
    count_ticks(200, n);
    check_eq("p100.ticks200", 32'(n), 32'd16);
    high_len("p100.high", h);
    check_eq("p100.high_6_7", 32'(h == 6 || h == 7), 32'd1);

    // filtered convergence from 0x0A00 toward 0x1400
    ref_cycles("pre_filt", 160, 2);
    bus.filt_en = 1'b1;
    ref_cycles("filt", 320, 4);
    check_eq("filt.hp3", 32'(bus.period), 32'h0FC8);
    check_eq("filt.nolock", 32'(bus.lock), 32'd0);
    ref_cycles("filt_conv", 320, 24);
    check_eq("filt.lock", 32'(bus.lock), 32'd1);
    bus.filt_en = 1'b0;

    // reference loss: counter saturates at 1023
    while (cyc - last_rise < 1000) @(negedge clk);
    check_eq("lost.before", 32'(bus.ref_lost), 32'd0);
    while (cyc - last_rise < 1040) @(negedge clk);
    check_eq("lost.flag", 32'(bus.ref_lost), 32'd1);
    check_eq("lost.lock", 32'(bus.lock), 32'd0);
    check_eq("lost.hp_hold", 32'(bus.period), 32'(m_hp));
    count_ticks(200, n);
    check_eq("lost.freerun", 32'(n >= 4), 32'd1);
    m_armed = 0; m_lost = 1; m_lock = 0; m_lc = 0;
    ref_cycles("relock", 160, 7);
    check_eq("relock.lost", 32'(bus.ref_lost), 32'd0);
    check_eq("relock.lock", 32'(bus.lock), 32'd1);

    // frozen half-period
    bus.enb_cp = 1'b1;
    ref_cycles("frozen", 200, 3);
    check_eq("frozen.hp", 32'(bus.period), 32'h0A00);
    check_eq("frozen.lock", 32'(bus.lock), 32'd0);
    bus.enb_cp = 1'b0;
    ref_cycles("thaw", 200, 2);
    check_eq("thaw.hp", 32'(bus.period), 32'h0C80);

    // generator disable in the middle of a high phase
    wait_level("vco", 1'b0, 100, n);
    wait_level("vco", 1'b1, 100, n);
    repeat (2) @(negedge clk);
    check_eq("vco.pre_high", 32'(bus.clk_out), 32'd1);
    bus.enb_vco = 1'b1;
    @(posedge clk); #1;
    check_eq("vco.off_clk", 32'(bus.clk_out), 32'd0);
    check_eq("vco.off_tick", 32'(bus.tick), 32'd0);
    t0 = tick_cnt;
    repeat (20) @(negedge clk);
    check_eq("vco.held", 32'(bus.clk_out), 32'd0);
    check_eq("vco.noticks", 32'(tick_cnt - t0), 32'd0);
    bus.enb_vco = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.clk_out !== 1'b1 && n < 50);
    check_eq("vco.first_rise", 32'(n), 32'd13);

    // asynchronous reset mid-run, then re-arm
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ref_cycles("rearm", 160, 3);
    check_eq("rearm.hp", 32'(bus.period), 32'h0A00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
